// File: rtl/axi_lite_regfile_pkg.sv
// Shared constants and helpers for the AXI4-Lite register file slice.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return r;
    endfunction

    // One byte lane of a strobed write; the caller iterates over lanes.
    function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                              input logic [7:0] new_b,
                                              input logic       en);
        return en ? new_b : old_b;
    endfunction

endpackage

// File: rtl/axi_lite_regfile_wr_capture.sv
// One-entry holding register for an AXI-Lite request channel (AW or W).
// Ready is a flop so there is no combinational path from valid to ready.
module axi_lite_wr_capture #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    input  logic         i_clear,
    output logic         o_ready,
    output logic         o_held,
    output logic [W-1:0] o_data
);

    logic         r_held;
    logic         r_ready;
    logic [W-1:0] r_data;
    logic         w_take;
    logic         w_held_nx;

    assign w_take    = i_valid & r_ready;
    assign w_held_nx = i_clear ? 1'b0 : (r_held | w_take);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_held  <= 1'b0;
            r_ready <= 1'b0;
            r_data  <= '0;
        end else begin
            r_held  <= w_held_nx;
            r_ready <= !w_held_nx;
            if (w_take) r_data <= i_data;
        end
    end

    assign o_ready = r_ready;
    assign o_held  = r_held;
    assign o_data  = r_data;

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file: NUM_REGS word registers with byte strobes,
// read-only status slots sourced from reg_in, SLVERR on RO/out-of-range access.
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int                   DATA_W    = 32,
    parameter int                   ADDR_W    = 32,
    parameter int                   NUM_REGS  = 8,
    parameter logic [NUM_REGS-1:0]  RO_MASK   = '0,
    parameter logic [DATA_W-1:0]    RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         awvalid,
    input  logic [ADDR_W-1:0]            awaddr,
    output logic                         awready,
    input  logic                         wvalid,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [DATA_W/8-1:0]          wstrb,
    output logic                         wready,
    output logic                         bvalid,
    output logic [1:0]                   bresp,
    input  logic                         bready,
    input  logic                         arvalid,
    input  logic [ADDR_W-1:0]            araddr,
    output logic                         arready,
    output logic                         rvalid,
    output logic [DATA_W-1:0]            rdata,
    output logic [1:0]                   rresp,
    input  logic                         rready,
    output logic [NUM_REGS*DATA_W-1:0]   reg_out,
    input  logic [NUM_REGS*DATA_W-1:0]   reg_in,
    output logic [NUM_REGS-1:0]          wr_pulse
);

    localparam int STRB_W   = DATA_W / 8;
    localparam int LSB      = clog2(STRB_W);
    localparam int IDX_W    = (clog2(NUM_REGS) < 1) ? 1 : clog2(NUM_REGS);
    localparam int IDX_SPAN = 1 << IDX_W;

    logic [DATA_W-1:0]        r_regs [NUM_REGS];
    logic                     r_bvalid;
    logic [1:0]               r_bresp;
    logic [NUM_REGS-1:0]      r_wr_pulse;
    logic                     r_ar_pending;
    logic [IDX_W-1:0]         r_ar_idx;
    logic                     r_arready;
    logic                     r_rvalid;
    logic [DATA_W-1:0]        r_rdata;
    logic [1:0]               r_rresp;

    logic                     w_aw_held;
    logic                     w_w_held;
    logic [IDX_W-1:0]         w_aw_idx;
    logic [STRB_W+DATA_W-1:0] w_w_bundle;
    logic [DATA_W-1:0]        w_wdata;
    logic [STRB_W-1:0]        w_wstrb;
    logic                     w_commit;
    logic                     w_wr_ok;
    logic [IDX_SPAN-1:0]      w_ro_ext;
    logic                     w_ar_pending_nx;
    logic                     w_rvalid_nx;
    logic                     w_unused;

    // Only the index bits are stored; upper address bits alias by design.
    axi_lite_wr_capture #(.W(IDX_W)) u_aw_cap (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (awvalid),
        .i_data  (awaddr[LSB +: IDX_W]),
        .i_clear (w_commit),
        .o_ready (awready),
        .o_held  (w_aw_held),
        .o_data  (w_aw_idx)
    );

    axi_lite_wr_capture #(.W(STRB_W + DATA_W)) u_w_cap (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (wvalid),
        .i_data  ({wstrb, wdata}),
        .i_clear (w_commit),
        .o_ready (wready),
        .o_held  (w_w_held),
        .o_data  (w_w_bundle)
    );

    assign {w_wstrb, w_wdata} = w_w_bundle;
    assign w_ro_ext = IDX_SPAN'(RO_MASK);
    assign w_commit = w_aw_held & w_w_held & ~r_bvalid;
    assign w_wr_ok  = (int'(w_aw_idx) < NUM_REGS) && !w_ro_ext[w_aw_idx];
    assign w_unused = ^{awaddr, araddr, reg_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RO_MASK[i] ? '0 : RESET_VAL;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (w_wr_ok && !RO_MASK[i] && (int'(w_aw_idx) == i)) begin
                        r_wr_pulse[i] <= 1'b1;
                        for (int b = 0; b < STRB_W; b++) begin
                            r_regs[i][b*8 +: 8] <= byte_merge(r_regs[i][b*8 +: 8],
                                                              w_wdata[b*8 +: 8], w_wstrb[b]);
                        end
                    end
                end
            end else if (r_bvalid && bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    always_comb begin
        w_ar_pending_nx = r_ar_pending;
        w_rvalid_nx     = r_rvalid;
        if (arvalid && r_arready) w_ar_pending_nx = 1'b1;
        if (r_ar_pending) begin
            w_ar_pending_nx = 1'b0;
            w_rvalid_nx     = 1'b1;
        end else if (r_rvalid && rready) begin
            w_rvalid_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ar_pending <= 1'b0;
            r_ar_idx     <= '0;
            r_arready    <= 1'b0;
            r_rvalid     <= 1'b0;
            r_rdata      <= '0;
            r_rresp      <= RESP_OKAY;
        end else begin
            r_ar_pending <= w_ar_pending_nx;
            r_rvalid     <= w_rvalid_nx;
            r_arready    <= !w_ar_pending_nx && !w_rvalid_nx;
            if (arvalid && r_arready) r_ar_idx <= araddr[LSB +: IDX_W];
            // Sampled on the same edge as a possible commit, so reads see the old value.
            if (r_ar_pending) begin
                r_rdata <= '0;
                r_rresp <= RESP_SLVERR;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (int'(r_ar_idx) == i) begin
                        r_rresp <= RESP_OKAY;
                        r_rdata <= RO_MASK[i] ? reg_in[i*DATA_W +: DATA_W] : r_regs[i];
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[g*DATA_W +: DATA_W] = RO_MASK[g] ? '0 : r_regs[g];
    end

    assign bvalid   = r_bvalid;
    assign bresp    = r_bresp;
    assign wr_pulse = r_wr_pulse;
    assign arready  = r_arready;
    assign rvalid   = r_rvalid;
    assign rdata    = r_rdata;
    assign rresp    = r_rresp;

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed self-checking bench for axi_lite_regfile (6 registers, register 5 read-only).
module tb_axi_lite_regfile;
    import axi_lite_pkg::*;

    localparam int              DW = 32;
    localparam int              AW = 32;
    localparam int              NR = 6;
    localparam logic [NR-1:0]   RO = 6'b100000;
    localparam logic [DW-1:0]   RV = 32'h0000_1111;

    logic               clk;
    logic               rst_n;
    logic               awvalid, awready, wvalid, wready, bvalid, bready;
    logic               arvalid, arready, rvalid, rready;
    logic [AW-1:0]      awaddr, araddr;
    logic [DW-1:0]      wdata, rdata;
    logic [3:0]         wstrb;
    logic [1:0]         bresp, rresp;
    logic [NR*DW-1:0]   reg_out, reg_in;
    logic [NR-1:0]      wr_pulse;

    int                 n_checks;
    int                 n_errors;
    logic [DW-1:0]      exp_reg [NR];

    axi_lite_regfile #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .RO_MASK(RO), .RESET_VAL(RV)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
        .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
        .bvalid(bvalid), .bresp(bresp), .bready(bready),
        .arvalid(arvalid), .araddr(araddr), .arready(arready),
        .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
        .reg_out(reg_out), .reg_in(reg_in), .wr_pulse(wr_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NR; i++)
            chk($sformatf("%s reg_out[%0d]", tag, i), reg_out[i*DW +: DW], exp_reg[i]);
    endtask

    task automatic reset_model();
        for (int i = 0; i < NR; i++) exp_reg[i] = RO[i] ? '0 : RV;
    endtask

    task automatic send_aw_w(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
        logic aw_hs, w_hs;
        int   g;
        g = 0;
        awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s;
        while ((awvalid || wvalid) && g < 20) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            if (aw_hs) awvalid = 1'b0;
            if (w_hs)  wvalid  = 1'b0;
            g++;
        end
        chk("aw_w_accepted", {31'b0, awvalid | wvalid}, 32'd0);
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic wait_b(output logic [1:0] resp, output int lat);
        lat = 0;
        while (!bvalid && lat < 20) begin
            tick();
            lat++;
        end
        resp = bresp;
    endtask

    task automatic finish_b();
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("bvalid_clear", {31'b0, bvalid}, 32'd0);
    endtask

    // Expected response and pulse are supplied by the caller; a nonzero pulse
    // marks the register the write lands in.
    task automatic write_chk(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                             input logic [1:0] exp_resp, input logic [NR-1:0] exp_pulse);
        logic [1:0] resp;
        int         lat;
        send_aw_w(a, d, s);
        wait_b(resp, lat);
        chk($sformatf("b_latency @%h", a), lat, 32'd1);
        chk($sformatf("bresp @%h", a), {30'b0, resp}, {30'b0, exp_resp});
        chk($sformatf("wr_pulse @%h", a), {26'b0, wr_pulse}, {26'b0, exp_pulse});
        for (int i = 0; i < NR; i++) begin
            if (exp_pulse[i]) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) exp_reg[i][b*8 +: 8] = d[b*8 +: 8];
            end
        end
        check_regs($sformatf("after write @%h", a));
        finish_b();
        chk($sformatf("wr_pulse_once @%h", a), {26'b0, wr_pulse}, 32'd0);
    endtask

    task automatic read_chk(input logic [AW-1:0] a, input logic [DW-1:0] exp_data,
                            input logic [1:0] exp_resp);
        int g;
        g = 0;
        arvalid = 1'b1; araddr = a;
        while (!arready && g < 20) begin
            tick();
            g++;
        end
        chk($sformatf("arready @%h", a), {31'b0, arready}, 32'd1);
        tick();
        arvalid = 1'b0;
        chk($sformatf("rvalid_early @%h", a), {31'b0, rvalid}, 32'd0);
        tick();
        chk($sformatf("rvalid @%h", a), {31'b0, rvalid}, 32'd1);
        chk($sformatf("rdata @%h", a), rdata, exp_data);
        chk($sformatf("rresp @%h", a), {30'b0, rresp}, {30'b0, exp_resp});
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk($sformatf("rvalid_clear @%h", a), {31'b0, rvalid}, 32'd0);
        chk($sformatf("arready_back @%h", a), {31'b0, arready}, 32'd1);
    endtask

    initial begin
        logic [1:0] resp;
        int         lat;
        int         g;

        n_checks = 0; n_errors = 0;
        rst_n = 1'b0;
        awvalid = 0; awaddr = '0; wvalid = 0; wdata = '0; wstrb = '0; bready = 0;
        arvalid = 0; araddr = '0; rready = 0;
        for (int i = 0; i < NR; i++) reg_in[i*DW +: DW] = 32'hC0DE_0000 | i;
        reset_model();

        // Reset state
        #12;
        chk("rst awready", {31'b0, awready}, 32'd0);
        chk("rst wready",  {31'b0, wready},  32'd0);
        chk("rst arready", {31'b0, arready}, 32'd0);
        chk("rst bvalid",  {31'b0, bvalid},  32'd0);
        chk("rst rvalid",  {31'b0, rvalid},  32'd0);
        chk("rst wr_pulse", {26'b0, wr_pulse}, 32'd0);
        check_regs("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // 1: read every index, including the two unmapped ones
        for (int i = 0; i < 8; i++) begin
            if (i < 5)       read_chk(AW'(i * 4), RV, RESP_OKAY);
            else if (i == 5) read_chk(AW'(i * 4), 32'hC0DE_0005, RESP_OKAY);
            else             read_chk(AW'(i * 4), 32'h0, RESP_SLVERR);
        end

        // 2: strobed write
        write_chk(32'h08, 32'h0000_0000, 4'b1111, RESP_OKAY, 6'b000100);
        write_chk(32'h08, 32'hDEAD_BEEF, 4'b0101, RESP_OKAY, 6'b000100);
        chk("reg2 strobed", reg_out[2*DW +: DW], 32'h00AD_00EF);
        read_chk(32'h08, 32'h00AD_00EF, RESP_OKAY);
        write_chk(32'h08, 32'hFFFF_FFFF, 4'b0000, RESP_OKAY, 6'b000100);
        chk("reg2 zero strobe", reg_out[2*DW +: DW], 32'h00AD_00EF);
        write_chk(32'h0E, 32'h1122_3344, 4'b1111, RESP_OKAY, 6'b001000);

        // 3: W three cycles ahead of AW
        wvalid = 1'b1; wdata = 32'hCAFE_F00D; wstrb = 4'b1111;
        g = 0;
        while (!wready && g < 20) begin
            tick();
            g++;
        end
        chk("w_only ready", {31'b0, wready}, 32'd1);
        tick();
        wvalid = 1'b0;
        tick();
        chk("w_only no b", {31'b0, bvalid}, 32'd0);
        tick();
        chk("w_only no b2", {31'b0, bvalid}, 32'd0);
        awvalid = 1'b1; awaddr = 32'h04;
        chk("late aw ready", {31'b0, awready}, 32'd1);
        tick();
        awvalid = 1'b0;
        wait_b(resp, lat);
        chk("split b_latency", lat, 32'd1);
        chk("split bresp", {30'b0, resp}, {30'b0, RESP_OKAY});
        chk("split wr_pulse", {26'b0, wr_pulse}, 32'h0000_0002);
        exp_reg[1] = 32'hCAFE_F00D;
        check_regs("split");
        finish_b();

        // 4: read-only and out-of-range writes, plus aliasing above the index bits
        write_chk(32'h14, 32'hFFFF_FFFF, 4'b1111, RESP_SLVERR, 6'b000000);
        read_chk(32'h14, 32'hC0DE_0005, RESP_OKAY);
        write_chk(32'h18, 32'hFFFF_FFFF, 4'b1111, RESP_SLVERR, 6'b000000);
        write_chk(32'h1C, 32'hFFFF_FFFF, 4'b1111, RESP_SLVERR, 6'b000000);
        read_chk(32'h18, 32'h0, RESP_SLVERR);
        write_chk(32'h20, 32'h0BAD_F00D, 4'b1111, RESP_OKAY, 6'b000001);
        read_chk(32'h00, 32'h0BAD_F00D, RESP_OKAY);
        reg_in[5*DW +: DW] = 32'h5555_AAAA;
        read_chk(32'h14, 32'h5555_AAAA, RESP_OKAY);

        // 5: back-to-back writes with B back-pressure
        send_aw_w(32'h10, 32'h4444_4444, 4'b1111);
        send_aw_w(32'h0C, 32'h3333_0000, 4'b1100);
        exp_reg[4] = 32'h4444_4444;
        chk("bp bvalid", {31'b0, bvalid}, 32'd1);
        chk("bp reg4", reg_out[4*DW +: DW], 32'h4444_4444);
        chk("bp awready held", {31'b0, awready}, 32'd0);
        chk("bp wready held", {31'b0, wready}, 32'd0);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp hold bvalid c%0d", c), {31'b0, bvalid}, 32'd1);
            chk($sformatf("bp hold bresp c%0d", c), {30'b0, bresp}, {30'b0, RESP_OKAY});
            chk($sformatf("bp hold reg3 c%0d", c), reg_out[3*DW +: DW], 32'h1122_3344);
            chk($sformatf("bp hold pulse c%0d", c), {26'b0, wr_pulse}, 32'd0);
            tick();
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("bp first b done", {31'b0, bvalid}, 32'd0);
        chk("bp reg3 not yet", reg_out[3*DW +: DW], 32'h1122_3344);
        tick();
        chk("bp second bvalid", {31'b0, bvalid}, 32'd1);
        chk("bp second bresp", {30'b0, bresp}, {30'b0, RESP_OKAY});
        chk("bp second pulse", {26'b0, wr_pulse}, 32'h0000_0008);
        exp_reg[3] = 32'h3333_3344;
        check_regs("back-to-back");
        finish_b();

        // 6: reset with an AW held and a read pending
        awvalid = 1'b1; awaddr = 32'h00; arvalid = 1'b1; araddr = 32'h04;
        g = 0;
        while (!(awready && arready) && g < 20) begin
            tick();
            g++;
        end
        tick();
        awvalid = 1'b0; arvalid = 1'b0;
        chk("pre-reset aw held", {31'b0, awready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid rst rvalid", {31'b0, rvalid}, 32'd0);
        chk("mid rst arready", {31'b0, arready}, 32'd0);
        chk("mid rst awready", {31'b0, awready}, 32'd0);
        chk("mid rst bvalid", {31'b0, bvalid}, 32'd0);
        reset_model();
        check_regs("mid reset");
        tick();
        tick();
        rst_n = 1'b1;
        wvalid = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("post rst rvalid c%0d", c), {31'b0, rvalid}, 32'd0);
            chk($sformatf("post rst bvalid c%0d", c), {31'b0, bvalid}, 32'd0);
            chk($sformatf("post rst pulse c%0d", c), {26'b0, wr_pulse}, 32'd0);
        end
        wvalid = 1'b0;
        check_regs("post reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
